// File: rtl/mlp_pkg.sv
// Shared types for the MLP neuron weight path: loader FSM states, bank index, bank count.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mlp_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_FREE = 2'd2
    } loader_state_t;

    typedef logic bank_idx_t;

    localparam int BANK_COUNT = 2;

endpackage

// File: rtl/bank_status_reg.sv
// Per-bank "full and unconsumed" flags: set by a completed fill, cleared by a reader release.
// Latency: set/clear visible the cycle after the request edge.
// Backpressure: none; a set and a release of the same bank in one cycle leaves the flag set.
// Ports: clk, reset (async active-low), clear (wipe all flags), set/set_idx (fill completed),
//        bank_release (one-hot reader release), flags (current bank state).
module bank_status_reg
    import mlp_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  set,
    input  bank_idx_t             set_idx,
    input  logic [BANK_COUNT-1:0] bank_release,
    output logic [BANK_COUNT-1:0] flags
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags <= '0;
        end else begin
            for (int b = 0; b < BANK_COUNT; b++) begin
                if (clear) begin
                    flags[b] <= 1'b0;
                end else if (set && (set_idx == bank_idx_t'(b))) begin
                    // A release arriving with the fill refers to the previous contents.
                    flags[b] <= 1'b1;
                end else if (bank_release[b]) begin
                    flags[b] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/weight_bank_loader.sv
// Ping-pong weight SRAM loader: turns a valid/ready word stream into SRAM write strobes, bank 0 then 1.
// Latency: word accepted at edge N -> new_weight/weight_out/bank_sel/write_address valid in cycle N+1.
// Backpressure: in_ready low outside LOAD, i.e. while idle or while the next bank is still unreleased.
// Ports: clk, reset (async active-low), start, in_valid/in_ready/in_data (upstream stream),
//        bank_release (one-hot reader done), new_weight/weight_out/bank_sel/write_address (SRAM write),
//        bank_ready/input_available (to read controller), done (one-cycle end-of-run pulse).
// Option: LOADER_STALL_CNT_EN adds stall_count[15:0], the saturating count of WAIT_FREE cycles
//        plus LOAD cycles without in_valid, cleared by reset and by an accepted start.
module weight_bank_loader
    import mlp_pkg::*;
#(
    parameter int INPUT_NUM  = 2,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_BLOCKS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [BANK_COUNT-1:0] bank_release,
    output logic                  new_weight,
    output logic [DATA_WIDTH-1:0] weight_out,
    output logic                  bank_sel,
    output logic [INPUT_NUM-1:0]  write_address,
    output logic [BANK_COUNT-1:0] bank_ready,
    output logic                  input_available,
    output logic                  done
`ifdef LOADER_STALL_CNT_EN
    ,
    output logic [15:0]           stall_count
`endif
);

    localparam int DEPTH = 2 ** INPUT_NUM;
    localparam int BLK_W = $clog2(NUM_BLOCKS + 1);

    loader_state_t        state, state_nxt;
    bank_idx_t            bank, bank_nxt;
    logic [INPUT_NUM-1:0] addr, addr_nxt;
    logic [BLK_W-1:0]     blk_cnt, blk_nxt;
    logic                 done_pend, done_pend_nxt;
    logic                 clear_all;
    logic                 xfer;
    logic                 last_word;

    assign in_ready        = (state == LOAD);
    assign xfer            = in_valid & in_ready;
    assign last_word       = xfer && (addr == INPUT_NUM'(DEPTH - 1));
    assign input_available = |bank_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bank      <= 1'b0;
            addr      <= '0;
            blk_cnt   <= '0;
            done_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            bank      <= bank_nxt;
            addr      <= addr_nxt;
            blk_cnt   <= blk_nxt;
            done_pend <= done_pend_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bank_nxt      = bank;
        addr_nxt      = addr;
        blk_nxt       = blk_cnt;
        done_pend_nxt = 1'b0;
        clear_all     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                    bank_nxt  = 1'b0;
                    addr_nxt  = '0;
                    blk_nxt   = '0;
                    clear_all = 1'b1;
                end
            end
            LOAD: begin
                if (xfer) begin
                    // DEPTH is a power of two, so the address wraps to 0 on the bank switch.
                    addr_nxt = addr + 1'b1;
                    if (last_word) begin
                        bank_nxt = ~bank;
                        blk_nxt  = blk_cnt + 1'b1;
                        if (blk_cnt == BLK_W'(NUM_BLOCKS - 1)) begin
                            state_nxt     = IDLE;
                            done_pend_nxt = 1'b1;
                        end else if (bank_ready[~bank] && !bank_release[~bank]) begin
                            // A release landing on this edge frees the bank in time: no stall.
                            state_nxt = WAIT_FREE;
                        end
                    end
                end
            end
            WAIT_FREE: begin
                if (!bank_ready[bank] || bank_release[bank]) begin
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Write-port outputs, registered one cycle behind the accepted word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            new_weight    <= 1'b0;
            weight_out    <= '0;
            bank_sel      <= 1'b0;
            write_address <= '0;
            done          <= 1'b0;
        end else begin
            new_weight <= xfer;
            done       <= done_pend;
            if (xfer) begin
                weight_out    <= in_data;
                bank_sel      <= bank;
                write_address <= addr;
            end
        end
    end

    bank_status_reg u_bank_status (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear_all),
        .set          (last_word),
        .set_idx      (bank),
        .bank_release (bank_release),
        .flags        (bank_ready)
    );

`ifdef LOADER_STALL_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (state == IDLE && start) begin
            stall_count <= '0;
        end else if ((state == WAIT_FREE || (state == LOAD && !in_valid)) &&
                     (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule
